// File: rtl/alu_operand_entry_pkg.sv
// rtl/alu_operand_entry_pkg.sv - shared entry-stage encoding and opcode field positions
package alu_operand_entry_pkg;

   // Entry stages; the numeric values also drive the status LEDs
   typedef enum logic [2:0] {
      S_A   = 3'd0,
      S_B   = 3'd1,
      S_OP  = 3'd2,
      S_SEL = 3'd3,
      S_RUN = 3'd4
   } state_t;

   // Opcode slice positions within the switch word
   localparam int MC_LSB  = 0;
   localparam int MC_W    = 2;
   localparam int MUX_LSB = 2;
   localparam int MUX_W   = 4;

   // Output-select bit positions within the switch word
   localparam int SEL_MUX_BIT = 0;
   localparam int SEL_MUL_BIT = 1;

endpackage

// File: rtl/alu_operand_entry_btn_debounce.sv
// rtl/alu_operand_entry_btn_debounce.sv - push-button synchroniser, debouncer and rise detector
module btn_debounce #(
   parameter int DEB_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise_pulse
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] TERM = CW'(DEB_CYCLES - 1);

   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          stable_q, stable_d;
   logic          rise_q, rise_d;

   // Next-state: count while the synced level disagrees, accept it at the terminal count
   always_comb begin
      sync_d   = {sync_q[0], raw};
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync_q[1] != stable_q) begin
         if (cnt_q == TERM) begin
            stable_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      rise_d = stable_d & ~stable_q;
   end

   // State registers, cleared immediately on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
         rise_q   <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         rise_q   <= rise_d;
      end
   end

   assign level      = stable_q;
   assign rise_pulse = rise_q;

endmodule

// File: rtl/alu_operand_entry.sv
// rtl/alu_operand_entry.sv - button-driven operand/opcode entry sequencer for the ALU top
module alu_operand_entry
   import alu_operand_entry_pkg::*;
#(
   parameter int WIDTH      = 6,
   parameter int DEB_CYCLES = 250000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw,
   input  logic             btn_next,
   input  logic             btn_clear,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic [MC_W-1:0]  MC,
   output logic [MUX_W-1:0] MUX,
   output logic             mux,
   output logic             MUL,
   output logic [2:0]       stage,
   output logic             op_valid,
   output logic             op_start
);

   logic [WIDTH-1:0] sw_meta_q, sw_sync_q;
   logic             next_pulse, clr_pulse;
   logic             next_level, clr_level;
   logic             unused_levels;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [MC_W-1:0]  mc_q, mc_d;
   logic [MUX_W-1:0] mux_fn_q, mux_fn_d;
   logic             mux_path_q, mux_path_d;
   logic             mul_q, mul_d;
   logic             op_valid_q, op_valid_d;
   logic             op_start_q, op_start_d;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
      .clk        (clk),
      .rst        (rst),
      .raw        (btn_next),
      .level      (next_level),
      .rise_pulse (next_pulse)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
      .clk        (clk),
      .rst        (rst),
      .raw        (btn_clear),
      .level      (clr_level),
      .rise_pulse (clr_pulse)
   );

   // Held levels are not needed here; only the press edges sequence entry
   assign unused_levels = next_level ^ clr_level;

   // Two-stage synchroniser for the slide switches
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         sw_meta_q <= sw;
         sw_sync_q <= sw_meta_q;
      end
   end

   // Entry sequencing: clear overrides next, fields hold unless captured
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      mc_d       = mc_q;
      mux_fn_d   = mux_fn_q;
      mux_path_d = mux_path_q;
      mul_d      = mul_q;
      if (clr_pulse) begin
         state_d    = S_A;
         a_d        = '0;
         b_d        = '0;
         mc_d       = '0;
         mux_fn_d   = '0;
         mux_path_d = 1'b0;
         mul_d      = 1'b0;
      end else if (next_pulse) begin
         case (state_q)
            S_A: begin
               a_d     = sw_sync_q;
               state_d = S_B;
            end
            S_B: begin
               b_d     = sw_sync_q;
               state_d = S_OP;
            end
            S_OP: begin
               mc_d     = sw_sync_q[MC_LSB +: MC_W];
               mux_fn_d = sw_sync_q[MUX_LSB +: MUX_W];
               state_d  = S_SEL;
            end
            S_SEL: begin
               mux_path_d = sw_sync_q[SEL_MUX_BIT];
               mul_d      = sw_sync_q[SEL_MUL_BIT];
               state_d    = S_RUN;
            end
            default: state_d = S_A;
         endcase
      end
      op_valid_d = (state_d == S_RUN);
      op_start_d = (state_d == S_RUN) && (state_q != S_RUN);
   end

   // Stage and field registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_A;
         a_q        <= '0;
         b_q        <= '0;
         mc_q       <= '0;
         mux_fn_q   <= '0;
         mux_path_q <= 1'b0;
         mul_q      <= 1'b0;
         op_valid_q <= 1'b0;
         op_start_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         mc_q       <= mc_d;
         mux_fn_q   <= mux_fn_d;
         mux_path_q <= mux_path_d;
         mul_q      <= mul_d;
         op_valid_q <= op_valid_d;
         op_start_q <= op_start_d;
      end
   end

   assign A        = a_q;
   assign B        = b_q;
   assign MC       = mc_q;
   assign MUX      = mux_fn_q;
   assign mux      = mux_path_q;
   assign MUL      = mul_q;
   assign stage    = state_q;
   assign op_valid = op_valid_q;
   assign op_start = op_start_q;

endmodule

// File: tb/tb_alu_operand_entry.sv
// tb/tb_alu_operand_entry.sv - self-checking bench for alu_operand_entry
module tb_alu_operand_entry;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] sw = '0;
   logic       btn_next = 1'b0;
   logic       btn_clear = 1'b0;
   logic [5:0] A, B;
   logic [1:0] MC;
   logic [3:0] MUX;
   logic       mux, MUL;
   logic [2:0] stage;
   logic       op_valid, op_start;

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;

   // Reference model: what the operator has committed so far
   logic [5:0] exp_a, exp_b;
   logic [1:0] exp_mc;
   logic [3:0] exp_mux;
   logic       exp_mx, exp_mul;
   int         exp_stage;
   int         exp_starts = 0;

   alu_operand_entry #(.WIDTH(6), .DEB_CYCLES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .sw        (sw),
      .btn_next  (btn_next),
      .btn_clear (btn_clear),
      .A         (A),
      .B         (B),
      .MC        (MC),
      .MUX       (MUX),
      .mux       (mux),
      .MUL       (MUL),
      .stage     (stage),
      .op_valid  (op_valid),
      .op_start  (op_start)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (op_start) start_cnt++;

   function automatic logic [23:0] obs_vec();
      return {A, B, MC, MUX, mux, MUL, stage, op_valid};
   endfunction

   function automatic logic [23:0] exp_vec();
      logic [2:0] st;
      st = 3'(exp_stage);
      return {exp_a, exp_b, exp_mc, exp_mux, exp_mx, exp_mul, st, (exp_stage == 4)};
   endfunction

   task automatic model_reset();
      exp_a = 0; exp_b = 0; exp_mc = 0; exp_mux = 0; exp_mx = 0; exp_mul = 0; exp_stage = 0;
   endtask

   task automatic model_next(input logic [5:0] s);
      case (exp_stage)
         0: exp_a = s;
         1: exp_b = s;
         2: begin exp_mc = 2'(s % 4); exp_mux = 4'(s / 4); end
         3: begin exp_mx = s[0]; exp_mul = s[1]; exp_starts++; end
         default: ;
      endcase
      exp_stage = (exp_stage + 1) % 5;
   endtask

   task automatic press(input logic do_next, input logic do_clr, input int hold);
      @(posedge clk); #1;
      btn_next = do_next;
      btn_clear = do_clr;
      repeat (hold) @(posedge clk);
      #1;
      btn_next = 1'b0;
      btn_clear = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic enter(input logic [5:0] s);
      @(posedge clk); #1;
      sw = s;
      press(1'b1, 1'b0, 10);
      model_next(s);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec() || op_start !== 1'b0) begin
         errors++;
         $display("FAIL reset: got %h op_start=%b, want %h op_start=0", obs_vec(), op_start, exp_vec());
      end
   endtask

   task automatic test_full_entry();
      int s0;
      s0 = start_cnt;
      enter(6'h2A);
      enter(6'h15);
      enter(6'b000111);
      enter(6'b000001);
      checks++;
      if (obs_vec() !== {6'h2A, 6'h15, 2'b11, 4'b0001, 1'b1, 1'b0, 3'd4, 1'b1} || obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL full_entry: got %h, want %h", obs_vec(), exp_vec());
      end
      checks++;
      if (start_cnt - s0 !== 1) begin
         errors++;
         $display("FAIL full_entry_op_start: got %0d cycles high, want 1", start_cnt - s0);
      end
   endtask

   task automatic test_bounce();
      int s0;
      s0 = start_cnt;
      sw = 6'h3C;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1 btn_next = 1'b1;
         @(posedge clk); #1;
         @(posedge clk); #1 btn_next = 1'b0;
         @(posedge clk); #1;
      end
      repeat (12) @(posedge clk);
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec() || start_cnt != s0) begin
         errors++;
         $display("FAIL bounce: got %h, want %h", obs_vec(), exp_vec());
      end
      press(1'b1, 1'b0, 10);
      model_next(sw);
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL clean_press_wrap: got %h, want %h", obs_vec(), exp_vec());
      end
      enter(6'h3F);
      checks++;
      if (A !== 6'h3F || B !== 6'h15 || obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL wrap_reload: got %h, want %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_clear();
      enter(6'h09);
      checks++;
      if (obs_vec() !== exp_vec() || stage !== 3'd2) begin
         errors++;
         $display("FAIL clear_setup: got %h, want %h", obs_vec(), exp_vec());
      end
      press(1'b0, 1'b1, 10);
      model_reset();
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL clear: got %h, want %h", obs_vec(), exp_vec());
      end
      sw = 6'h11;
      press(1'b1, 1'b1, 10);
      model_reset();
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL clear_and_next: got %h, want %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_async_reset();
      enter(6'h0C);
      @(posedge clk); #1 btn_next = 1'b1;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (obs_vec() !== exp_vec() || op_start !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got %h, want %h", obs_vec(), exp_vec());
      end
      btn_next = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (12) @(posedge clk);
      enter(6'h25);
      checks++;
      if (obs_vec() !== exp_vec() || A !== 6'h25 || B !== 6'h00) begin
         errors++;
         $display("FAIL post_reset_entry: got %h, want %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_random();
      logic [5:0] s;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            sw = 6'($urandom);
            press(1'b0, 1'b1, 8 + $urandom_range(0, 4));
            model_reset();
         end else begin
            s = 6'($urandom);
            enter(s);
         end
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL random_step%0d: got %h, want %h", i, obs_vec(), exp_vec());
         end
      end
      checks++;
      if (start_cnt != exp_starts) begin
         errors++;
         $display("FAIL op_start_total: got %0d, want %0d", start_cnt, exp_starts);
      end
   endtask

   initial begin
      test_reset();
      test_full_entry();
      test_bounce();
      test_clear();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
